ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction fetch stage between the program counter and decode. Each cycle it presents `IP` to a combinational-read instruction memory and captures the returned word, PC and PC+4 into the IF/ID register. It feeds the opcode back to the program counter. A three-state control-flow FSM squashes shadow fetches around branches and jumps, replacing them with NOP bubbles.

## Interface
- `NOP_WORD`, default 32'h00000013: bubble instruction (addi x0,x0,0) driven when a slot is invalid.
- `CLK`  in  1: clock, all state updates on posedge.
- `RESET`  in  1: synchronous, active-high.
- `IP`  in  32: fetch address from the program counter.
- `PC_def`  in  32: IP+4 from the program counter.
- `b_taken`  in  1: branch resolution; sampled only in RESOLVE.
- `imem_addr`  out  32: instruction memory address, equals `IP` combinationally.
- `imem_rdata`  in  32: instruction word, valid in the same cycle as `imem_addr`.
- `INSTR`  out  32: IF/ID instruction; `NOP_WORD` when `ID_VALID`=0.
- `ID_PC`  out  32: PC of `INSTR`.
- `ID_PC4`  out  32: PC+4 of `INSTR`.
- `ID_VALID`  out  1: IF/ID slot holds a real instruction.
- `OP`  out  7: `INSTR[6:0]`, routed to the program counter.
- `FETCH_CNT`  out  32: valid instructions captured (see Configuration).
- `SQUASH_CNT`  out  32: squashed slots (see Configuration).

## Operation
- Control-flow (CF) opcodes:
  - JAL 7'b1101111 and JALR 7'b1100111 are jumps.
  - 7'b1100011 is a conditional branch.
- FSM states: RUN, RESOLVE, REDIRECT. Each posedge performs two actions: capture into IF/ID (`INSTR_q`<=`imem_rdata`, `ID_PC`<=`IP`, `ID_PC4`<=`PC_def`, `ID_VALID`<=cap_valid) and a state transition.
- RUN with `ID_VALID`=1 and a CF opcode in IF/ID:
  - cap_valid=0.
  - `is_jump_q` <= (OP is JAL or JALR).
  - next state RESOLVE.
- RUN otherwise: cap_valid=1, stay RUN.
- RESOLVE:
  - cap_valid=0.
  - Next state is REDIRECT if `b_taken` or `is_jump_q`, else RUN.
- REDIRECT: cap_valid=1 (jump target word), next state RUN.
- A CF instruction captured by REDIRECT or RUN is handled normally on the following cycle (back-to-back CF allowed).
- `b_taken` is ignored outside RESOLVE.
- The `INSTR` and `OP` mux is combinational on registered state: invalid slot gives `NOP_WORD` and OP 7'b0010011, which is never CF.
- Invalid slots still capture `ID_PC` and `ID_PC4`; the values are don't-care to decode.

## Timing
- Fetch-to-decode latency is 1 cycle: word at `IP` in cycle t appears on `INSTR` in t+1.
- The CF instruction is visible on `OP` in cycle t+1.
- Bubbles:
  - Not-taken branch: IF/ID invalid in t+2 and t+3; first valid word at t+4.
  - Taken branch or jump: invalid in t+2 and t+3; target word captured in REDIRECT, valid at t+4.
- Reset values:
  - state RUN, `ID_VALID`=0.
  - `INSTR`=`NOP_WORD`, `OP`=7'b0010011.
  - `ID_PC`=0, `ID_PC4`=0, `is_jump_q`=0.
  - Both counters 0.
- `RESET` asserted in any state forces RUN with an invalid slot on the next cycle. A pending branch is dropped.
- `imem_addr` has no register; it follows `IP` with zero latency, including during reset.

## Configuration
- Macro `IFETCH_PERF_EN`.
- Defined:
  - `FETCH_CNT` increments on each posedge with cap_valid=1.
  - `SQUASH_CNT` increments on each posedge with cap_valid=0 and not in reset.
  - Both wrap from 32'hFFFFFFFF to 0.
  - Both clear on `RESET`.
- Undefined: both ports tied to 32'b0 and no counter flops are inferred.
- Ports exist in both builds.

## Structure
- Package `ifetch_pkg`:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH, OP_OPIMM.
  - NOP constant.
  - enum `fetch_state_t` {RUN, RESOLVE, REDIRECT}.
  - function `is_cf(op)`.
- Sub-module `ifetch_perf`: the two counters plus wrap logic, instantiated only under `IFETCH_PERF_EN`.

## Test plan
- Reset then straight-line code:
  - Stimulus: `IP` 0,4,8, rdata 32'h00100093, 32'h00200113, 32'h00300193.
  - Response: `INSTR` follows one cycle later with `ID_VALID`=1, `ID_PC` 0,4,8. `FETCH_CNT`=3 with the macro, 0 without.
- Not-taken branch:
  - Stimulus: rdata 32'h00208463 at IP 8, `b_taken`=0 in RESOLVE.
  - Response: two NOP slots (`OP`=7'b0010011), then RUN; `SQUASH_CNT`=2.
- Taken branch:
  - Stimulus: same word, `b_taken`=1 in RESOLVE, `IP`=32'h40 in REDIRECT.
  - Response: `ID_PC`=32'h40 with `ID_VALID`=1 at t+4.
- JAL 32'h010000EF with `b_taken`=0: still goes through REDIRECT; target slot valid.
- `b_taken`=1 pulsed in RUN with no CF in IF/ID: no state change, no squash.
- `RESET` asserted during RESOLVE: next cycle state RUN, `ID_VALID`=0, counters 0, and the following fetch is valid.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: RV32 opcode constants,
// the bubble instruction, the control-flow FSM state type and opcode helpers.
package ifetch_pkg;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;

  // addi x0,x0,0 -- harmless bubble injected into squashed slots
  localparam logic [31:0] NOP       = 32'h00000013;

  typedef enum logic [1:0] {
    RUN,
    RESOLVE,
    REDIRECT
  } fetch_state_t;

  // Opcodes whose successor fetches are speculative and must be squashed
  function automatic logic is_cf(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

  // Unconditional control flow: always redirects, regardless of b_taken
  function automatic logic is_jump(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/ifetch_perf.sv
// Fetch-stage performance counters: captured valid instructions and squashed
// slots. Both wrap naturally at 32 bits and clear on RESET.
module ifetch_perf (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cap_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
);

  // Count every IF/ID capture as either a real fetch or a squash
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt  <= 32'd0;
      squash_cnt <= 32'd0;
    end else if (cap_valid) begin
      fetch_cnt  <= fetch_cnt + 32'd1;
    end else begin
      squash_cnt <= squash_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: drives the instruction memory address from IP,
// captures the returned word with its PC and PC+4 into the IF/ID register and
// squashes the two shadow fetches behind every branch or jump.
// Optional feature macro: IFETCH_PERF_EN (fetch/squash counters); when it is
// undefined FETCH_CNT and SQUASH_CNT read as zero.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IP,
  input  logic [31:0] PC_def,
  input  logic        b_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INSTR,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic        ID_VALID,
  output logic [6:0]  OP,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] SQUASH_CNT
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  instr_q;
  logic         is_jump_q;
  logic         cap_valid;
  logic         cf_in_slot;

  // The memory is combinational-read, so the address is IP with no register
  assign imem_addr = IP;

  // Invalid slots present a bubble; OP_OPIMM is never control flow
  assign INSTR = ID_VALID ? instr_q      : NOP_WORD;
  assign OP    = ID_VALID ? instr_q[6:0] : OP_OPIMM;

  assign cf_in_slot = ID_VALID && is_cf(instr_q[6:0]);

  // Decide whether this edge captures a real instruction and where the FSM goes
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    cap_valid  = 1'b1;
    next_state = state;
    case (state)
      RUN: begin
        if (cf_in_slot) begin
          cap_valid  = 1'b0;
          next_state = RESOLVE;
        end
      end
      RESOLVE: begin
        cap_valid  = 1'b0;
        next_state = (b_taken || is_jump_q) ? REDIRECT : RUN;
      end
      REDIRECT: begin
        cap_valid  = 1'b1;
        next_state = RUN;
      end
      default: begin
        cap_valid  = 1'b0;
        next_state = RUN;
      end
    endcase
  end

  // IF/ID capture and FSM state update
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state     <= RUN;
      ID_VALID  <= 1'b0;
      instr_q   <= NOP_WORD;
      ID_PC     <= 32'd0;
      ID_PC4    <= 32'd0;
      is_jump_q <= 1'b0;
    end else begin
      state    <= next_state;
      ID_VALID <= cap_valid;
      instr_q  <= imem_rdata;
      ID_PC    <= IP;
      ID_PC4   <= PC_def;
      if (state == RUN && cf_in_slot) begin
        is_jump_q <= is_jump(instr_q[6:0]);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  ifetch_perf u_perf (
    .CLK        (CLK),
    .RESET      (RESET),
    .cap_valid  (cap_valid),
    .fetch_cnt  (FETCH_CNT),
    .squash_cnt (SQUASH_CNT)
  );
`else
  assign FETCH_CNT  = 32'd0;
  assign SQUASH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: straight-line fetch, not-taken and taken
// branches, jumps (including back-to-back control flow), a stray b_taken
// pulse and reset in the middle of branch resolution.
module tb_ifetch_stage;

  localparam logic [31:0] NOP_W  = 32'h00000013;
  localparam logic [31:0] BEQ_W  = 32'h00208463;
  localparam logic [31:0] JAL_W  = 32'h010000EF;
  localparam logic [31:0] JALR_W = 32'h00008067;
  localparam logic [31:0] JUNK_W = 32'h0FF00F93;

`ifdef IFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IP;
  logic [31:0] PC_def;
  logic        b_taken;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] INSTR;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC4;
  logic        ID_VALID;
  logic [6:0]  OP;
  logic [31:0] FETCH_CNT;
  logic [31:0] SQUASH_CNT;

  int checks = 0;
  int errors = 0;

  ifetch_stage dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IP         (IP),
    .PC_def     (PC_def),
    .b_taken    (b_taken),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .INSTR      (INSTR),
    .ID_PC      (ID_PC),
    .ID_PC4     (ID_PC4),
    .ID_VALID   (ID_VALID),
    .OP         (OP),
    .FETCH_CNT  (FETCH_CNT),
    .SQUASH_CNT (SQUASH_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one fetch, check the combinational address, then clock it in
  task automatic step(input logic [31:0] ip, input logic [31:0] word, input logic bt);
    IP         = ip;
    PC_def     = ip + 32'd4;
    imem_rdata = word;
    b_taken    = bt;
    #1;
    check($sformatf("imem_addr@%h", ip), imem_addr, ip);
    @(posedge CLK);
    #1;
  endtask

  // Check the IF/ID slot contents after the most recent edge
  task automatic slot(input string tag, input logic valid, input logic [31:0] word,
                      input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, ID_VALID}, {31'd0, valid});
    if (valid) begin
      check({tag, ".instr"}, INSTR, word);
      check({tag, ".op"}, {25'd0, OP}, {25'd0, word[6:0]});
      check({tag, ".pc"}, ID_PC, pc);
      check({tag, ".pc4"}, ID_PC4, pc + 32'd4);
    end else begin
      check({tag, ".instr"}, INSTR, NOP_W);
      check({tag, ".op"}, {25'd0, OP}, 32'h13);
    end
  endtask

  task automatic counters(input string tag, input int fetches, input int squashes);
    check({tag, ".fetch_cnt"}, FETCH_CNT, PERF ? 32'(fetches) : 32'd0);
    check({tag, ".squash_cnt"}, SQUASH_CNT, PERF ? 32'(squashes) : 32'd0);
  endtask

  initial begin
    RESET      = 1'b1;
    IP         = 32'h0000_1234;
    PC_def     = 32'h0000_1238;
    b_taken    = 1'b0;
    imem_rdata = JUNK_W;

    // Reset state; address still follows IP while in reset
    step(32'h1234, JUNK_W, 1'b1);
    step(32'h1234, JUNK_W, 1'b0);
    slot("reset", 1'b0, NOP_W, 32'd0);
    check("reset.id_pc", ID_PC, 32'd0);
    check("reset.id_pc4", ID_PC4, 32'd0);
    counters("reset", 0, 0);
    RESET = 1'b0;

    // Straight-line code
    step(32'h00, 32'h00100093, 1'b0);  slot("line0", 1'b1, 32'h00100093, 32'h00);
    step(32'h04, 32'h00200113, 1'b0);  slot("line1", 1'b1, 32'h00200113, 32'h04);
    step(32'h08, 32'h00300193, 1'b0);  slot("line2", 1'b1, 32'h00300193, 32'h08);
    counters("line", 3, 0);

    // Not-taken branch: two bubbles then normal flow
    step(32'h0C, BEQ_W, 1'b0);         slot("nt.br", 1'b1, BEQ_W, 32'h0C);
    step(32'h10, JUNK_W, 1'b0);        slot("nt.b1", 1'b0, NOP_W, 32'h0);
    step(32'h14, JUNK_W, 1'b0);        slot("nt.b2", 1'b0, NOP_W, 32'h0);
    step(32'h18, 32'h00500293, 1'b0);  slot("nt.next", 1'b1, 32'h00500293, 32'h18);
    counters("nt", 5, 2);

    // Taken branch: b_taken in RESOLVE, target fetched in REDIRECT
    step(32'h1C, BEQ_W, 1'b0);         slot("tk.br", 1'b1, BEQ_W, 32'h1C);
    step(32'h20, JUNK_W, 1'b0);        slot("tk.b1", 1'b0, NOP_W, 32'h0);
    step(32'h24, JUNK_W, 1'b1);        slot("tk.b2", 1'b0, NOP_W, 32'h0);
    step(32'h40, 32'h00600313, 1'b0);  slot("tk.tgt", 1'b1, 32'h00600313, 32'h40);
    counters("tk", 7, 4);

    // JAL with b_taken low still redirects; target is a JALR (back-to-back CF)
    step(32'h44, JAL_W, 1'b0);         slot("jal", 1'b1, JAL_W, 32'h44);
    step(32'h48, JUNK_W, 1'b0);        slot("jal.b1", 1'b0, NOP_W, 32'h0);
    step(32'h4C, JUNK_W, 1'b0);        slot("jal.b2", 1'b0, NOP_W, 32'h0);
    step(32'h54, JALR_W, 1'b0);        slot("jalr", 1'b1, JALR_W, 32'h54);
    step(32'h58, JUNK_W, 1'b0);        slot("jalr.b1", 1'b0, NOP_W, 32'h0);
    step(32'h5C, JUNK_W, 1'b0);        slot("jalr.b2", 1'b0, NOP_W, 32'h0);
    step(32'h80, 32'h00800413, 1'b0);  slot("jalr.tgt", 1'b1, 32'h00800413, 32'h80);
    counters("jump", 10, 8);

    // Stray b_taken in RUN with no CF in IF/ID: no squash
    step(32'h84, 32'h00900493, 1'b1);  slot("stray0", 1'b1, 32'h00900493, 32'h84);
    step(32'h88, 32'h00A00513, 1'b1);  slot("stray1", 1'b1, 32'h00A00513, 32'h88);
    step(32'h8C, 32'h00B00593, 1'b0);  slot("stray2", 1'b1, 32'h00B00593, 32'h8C);
    counters("stray", 13, 8);

    // Reset while in RESOLVE drops the pending taken branch
    step(32'h90, BEQ_W, 1'b0);         slot("rr.br", 1'b1, BEQ_W, 32'h90);
    step(32'h94, JUNK_W, 1'b0);        slot("rr.b1", 1'b0, NOP_W, 32'h0);
    counters("rr.pre", 14, 9);
    RESET = 1'b1;
    step(32'h98, JUNK_W, 1'b1);        slot("rr.rst", 1'b0, NOP_W, 32'h0);
    check("rr.rst.id_pc", ID_PC, 32'd0);
    counters("rr.rst", 0, 0);
    RESET = 1'b0;
    step(32'h9C, 32'h00C00613, 1'b0);  slot("rr.next", 1'b1, 32'h00C00613, 32'h9C);
    step(32'hA0, 32'h00D00693, 1'b0);  slot("rr.next2", 1'b1, 32'h00D00693, 32'hA0);
    counters("rr.post", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
